mdu_iter: RTL



---
 rtl/mdu_iter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter - multi-cycle multiply/divide unit with architectural HI/LO.
//
// The result is computed when the operation is issued and parked in a pending
// register pair. After a fixed latency (MULT_CYCLES or DIV_CYCLES) it is
// committed to HI/LO. During that time the pipeline stalls on `busy`.
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu (1..63)
//   DIV_CYCLES   busy duration of div/divu   (1..63)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-low reset; clears all state
//   start   in   issue strobe (honoured only while idle)
//   op      in   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//                11x no-op
//   A       in   rs operand: multiplicand / dividend / mthi-mtlo value
//   B       in   rt operand: multiplier / divisor
//   abort   in   cancel the in-flight operation (only with MDU_ABORT_EN)
//   busy    out  operation in flight
//   hi, lo  out  architectural HI / LO registers
//
// Build option: define MDU_ABORT_EN to add the `abort` port.
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_res_hi, w_res_hi_nxt;
    logic [31:0] r_res_lo, w_res_lo_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic        w_abort;

`ifdef MDU_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // ---------------------------------------------------------------- multiply
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // ---------------------------------------------------------------- divide
    // One unsigned divider serves both div and divu. For div, the operands are
    // reduced to magnitudes and the signs are restored afterwards. The quotient
    // is negated when the operand signs differ. The remainder takes the
    // dividend's sign. 0x80000000 / -1 wraps to 0x80000000 rem 0 naturally.
    logic        w_sgn;
    logic [31:0] w_num, w_den, w_den_safe, w_q_mag, w_r_mag, w_quo, w_rem;
    logic        w_div0;

    assign w_sgn      = (op == 3'b010);
    assign w_num      = (w_sgn && A[31]) ? -A : A;
    assign w_den      = (w_sgn && B[31]) ? -B : B;
    assign w_div0     = (B == 32'd0);
    // The safe divisor keeps the divider defined when B is zero. That result
    // is never used.
    assign w_den_safe = w_div0 ? 32'd1 : w_den;
    assign w_q_mag    = w_num / w_den_safe;
    assign w_r_mag    = w_num % w_den_safe;
    assign w_quo      = (w_sgn && (A[31] ^ B[31])) ? -w_q_mag : w_q_mag;
    assign w_rem      = (w_sgn && A[31]) ? -w_r_mag : w_r_mag;

    // ---------------------------------------------------------------- control
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_res_hi_nxt = r_res_hi;
        w_res_lo_nxt = r_res_lo;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;

        case (r_state)
            IDLE: begin
                if (start && !w_abort) begin
                    case (op)
                        3'b000: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_prod_s;
                            w_cnt_nxt   = MULT_LOAD;
                            w_state_nxt = BUSY;
                        end
                        3'b001: begin
                            {w_res_hi_nxt, w_res_lo_nxt} = w_prod_u;
                            w_cnt_nxt   = MULT_LOAD;
                            w_state_nxt = BUSY;
                        end
                        3'b010, 3'b011: begin
                            // A zero divisor parks the current HI/LO. The
                            // commit then leaves them unchanged. HI/LO cannot
                            // move while busy.
                            w_res_hi_nxt = w_div0 ? r_hi : w_rem;
                            w_res_lo_nxt = w_div0 ? r_lo : w_quo;
                            w_cnt_nxt    = DIV_LOAD;
                            w_state_nxt  = BUSY;
                        end
                        3'b100:  w_hi_nxt = A;
                        3'b101:  w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 6'd0) begin
                    w_hi_nxt    = r_res_hi;
                    w_lo_nxt    = r_res_lo;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 6'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_res_hi <= w_res_hi_nxt;
            r_res_lo <= w_res_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign busy = (r_state == BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
